// File: rtl/srt4_host_pkg.sv
// Shared types and constants for the SRT4 divider host sequencer.
package srt4_host_pkg;

  localparam int unsigned BusWidth = 8;

  // Quotient reported when the divisor is zero and no launch takes place.
  localparam logic [BusWidth-1:0] DZ_QUOTIENT = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StWaitEnd,
    StCapR,
    StDone
  } state_e;

endpackage

// File: rtl/srt4_host_wait_counter.sv
// Saturating up-counter bounding the time spent waiting for the divider.
module wait_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntW'(TIMEOUT))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted in the cycle whose increment brings the count to TIMEOUT, so the
  // waiting state never lasts more than TIMEOUT cycles.
  assign hit_o = (cnt_q >= CntW'(TIMEOUT - 1));

endmodule

// File: rtl/srt4_host.sv
// Host-side sequencer: launches the SRT4 divider over its serial bus and
// returns quotient/remainder on a valid/ready result channel.
module srt4_host
  import srt4_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [BusWidth-1:0] req_dividend,
  input  logic [BusWidth-1:0] req_divisor,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [BusWidth-1:0] res_quotient,
  output logic [BusWidth-1:0] res_remainder,
  output logic                res_dz,
  output logic                res_err,
  output logic [BusWidth-1:0] inbus,
  output logic                beginSignal,
  input  logic [BusWidth-1:0] outbus,
  input  logic                endSignal,
  output logic                busy
);

  state_e state_q, state_d;

  logic [BusWidth-1:0] a_q, a_d;
  logic [BusWidth-1:0] b_q, b_d;
  logic [BusWidth-1:0] quo_q, quo_d;
  logic [BusWidth-1:0] rem_q, rem_d;
  logic [BusWidth-1:0] inbus_q, inbus_d;
  logic                dz_q, dz_d;
  logic                err_q, err_d;
  logic                begin_q, begin_d;

  logic cnt_clr, cnt_en, cnt_hit;

  wait_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_counter (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .hit_o(cnt_hit)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d   = req_dividend;
          b_d   = req_divisor;
          err_d = 1'b0;
          if (req_divisor == '0) begin
            dz_d    = 1'b1;
            quo_d   = DZ_QUOTIENT;
            rem_d   = req_dividend;
            state_d = StDone;
          end else begin
            dz_d    = 1'b0;
            quo_d   = '0;
            rem_d   = '0;
            state_d = StLoadA;
          end
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: begin
        cnt_clr = 1'b1;
        state_d = StWaitEnd;
      end
      StWaitEnd: begin
        cnt_en = 1'b1;
        if (endSignal) begin
          quo_d   = outbus;
          state_d = StCapR;
        end else if (cnt_hit) begin
          err_d   = 1'b1;
          quo_d   = '0;
          rem_d   = '0;
          state_d = StDone;
        end
      end
      StCapR: begin
        // A missing second endSignal cycle is flagged but the data is kept.
        rem_d   = outbus;
        err_d   = ~endSignal;
        state_d = StDone;
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus outputs are registered, so they are derived from the next state.
    begin_d = (state_d == StLoadA);
    unique case (state_d)
      StLoadA:                    inbus_d = a_d;
      StLoadB, StWaitEnd, StCapR: inbus_d = b_d;
      default:                    inbus_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
      begin_q <= 1'b0;
      inbus_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
      begin_q <= begin_d;
      inbus_q <= inbus_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign res_valid     = (state_q == StDone);
  assign res_quotient  = quo_q;
  assign res_remainder = rem_q;
  assign res_dz        = dz_q;
  assign res_err       = err_q;
  assign beginSignal   = begin_q;
  assign inbus         = inbus_q;

endmodule

// File: tb/tb_srt4_host.sv
// Bench for srt4_host with a behavioural divider that can also act as a
// silent or truncated-endSignal stub.
module tb_srt4_host;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_dividend = '0;
  logic [7:0] req_divisor = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_quotient;
  logic [7:0] res_remainder;
  logic       res_dz;
  logic       res_err;
  logic [7:0] inbus;
  logic       beginSignal;
  logic [7:0] outbus = '0;
  logic       endSignal = 1'b0;
  logic       busy;

  always #5 clk = ~clk;

  srt4_host #(
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_quotient (res_quotient),
    .res_remainder(res_remainder),
    .res_dz       (res_dz),
    .res_err      (res_err),
    .inbus        (inbus),
    .beginSignal  (beginSignal),
    .outbus       (outbus),
    .endSignal    (endSignal),
    .busy         (busy)
  );

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       err;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   begin_cnt = 0;

  // Divider model: 0 = real divider, 1 = never ends, 2 = endSignal for one cycle only.
  int         m_mode = 0;
  int         m_t = 0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_t       <= 0;
      endSignal <= 1'b0;
      outbus    <= '0;
    end else begin
      endSignal <= 1'b0;
      outbus    <= '0;
      if (beginSignal) begin
        m_a <= inbus;
        m_t <= 1;
      end else if (m_t == 1) begin
        m_b <= inbus;
        m_t <= 2;
      end else if (m_t >= 2 && m_t < 6) begin
        m_t <= m_t + 1;
        if (m_t == 4 && m_mode != 1) begin
          endSignal <= 1'b1;
          outbus    <= (m_mode == 0) ? m_a / m_b : 8'd9;
        end
        if (m_t == 5 && m_mode != 1) begin
          endSignal <= (m_mode == 0);
          outbus    <= (m_mode == 0) ? m_a % m_b : 8'd3;
        end
      end else begin
        m_t <= 0;
      end
    end
  end

  always @(posedge clk) begin
    if (beginSignal === 1'b1) begin_cnt <= begin_cnt + 1;
  end

  // Scoreboard: every completed result handshake is checked against the queue.
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      res_t exp;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got q=%0d r=%0d dz=%0b err=%0b, required no result",
                 res_quotient, res_remainder, res_dz, res_err);
      end else begin
        exp = sb.pop_front();
        if ({res_quotient, res_remainder, res_dz, res_err} !== exp) begin
          errors++;
          $display("FAIL result: got q=%0d r=%0d dz=%0b err=%0b, required q=%0d r=%0d dz=%0b err=%0b",
                   res_quotient, res_remainder, res_dz, res_err, exp.q, exp.r, exp.dz, exp.err);
        end
      end
    end
  end

  task automatic drive_req(input logic [7:0] a, input logic [7:0] b, input res_t exp);
    req_dividend = a;
    req_divisor  = b;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back(exp);
  endtask

  // Waits for res_valid; lat counts cycles after the request handshake edge.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (res_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({req_ready, busy, res_valid, res_dz, res_err, beginSignal} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 100000",
               {req_ready, busy, res_valid, res_dz, res_err, beginSignal});
    end
    checks++;
    if ({inbus, res_quotient, res_remainder} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 000000", {inbus, res_quotient, res_remainder});
    end
  endtask

  task automatic test_divide();
    int lat;
    int b0 = begin_cnt;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL div_ready: got %b, required 1", req_ready);
    end
    drive_req(8'd101, 8'd5, '{q: 8'd20, r: 8'd1, dz: 1'b0, err: 1'b0});
    checks++;
    if (beginSignal !== 1'b1 || inbus !== 8'd101) begin
      errors++;
      $display("FAIL div_launch: got begin=%b inbus=%0d, required begin=1 inbus=101",
               beginSignal, inbus);
    end
    @(posedge clk); #1;
    checks++;
    if (beginSignal !== 1'b0 || inbus !== 8'd5) begin
      errors++;
      $display("FAIL div_divisor: got begin=%b inbus=%0d, required begin=0 inbus=5",
               beginSignal, inbus);
    end
    wait_valid(2, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL div_latency: got %0d, required 8", lat);
    end
    checks++;
    if (inbus !== 8'd0 || beginSignal !== 1'b0) begin
      errors++;
      $display("FAIL div_done_bus: got inbus=%0d begin=%b, required 0 0", inbus, beginSignal);
    end
    ack();
    checks++;
    if (begin_cnt - b0 != 1) begin
      errors++;
      $display("FAIL div_pulses: got %0d, required 1", begin_cnt - b0);
    end
  endtask

  task automatic test_div_zero();
    int b0 = begin_cnt;
    drive_req(8'd37, 8'd0, '{q: 8'hFF, r: 8'd37, dz: 1'b1, err: 1'b0});
    checks++;
    if (res_valid !== 1'b1 || beginSignal !== 1'b0) begin
      errors++;
      $display("FAIL dz_latency: got valid=%b begin=%b, required valid=1 begin=0",
               res_valid, beginSignal);
    end
    ack();
    checks++;
    if (begin_cnt != b0) begin
      errors++;
      $display("FAIL dz_pulses: got %0d, required 0", begin_cnt - b0);
    end
  endtask

  task automatic test_timeout();
    int lat;
    m_mode = 1;
    drive_req(8'd77, 8'd3, '{q: 8'd0, r: 8'd0, dz: 1'b0, err: 1'b1});
    wait_valid(1, lat);
    checks++;
    if (lat != 11) begin
      errors++;
      $display("FAIL timeout_latency: got %0d, required 11", lat);
    end
    ack();
    m_mode = 0;
  endtask

  task automatic test_short_end();
    int lat;
    m_mode = 2;
    drive_req(8'd60, 8'd6, '{q: 8'd9, r: 8'd3, dz: 1'b0, err: 1'b1});
    wait_valid(1, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL short_latency: got %0d, required 8", lat);
    end
    ack();
    m_mode = 0;
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_req(8'd12, 8'd4, '{q: 8'd3, r: 8'd0, dz: 1'b0, err: 1'b0});
    wait_valid(1, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_quotient !== 8'd3 ||
          res_remainder !== 8'd0) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b ready=%b q=%0d r=%0d, required 1 0 3 0",
                 i, res_valid, req_ready, res_quotient, res_remainder);
      end
    end
    ack();
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got ready=%b valid=%b, required 1 0", req_ready, res_valid);
    end
    drive_req(8'd200, 8'd7, '{q: 8'd28, r: 8'd4, dz: 1'b0, err: 1'b0});
    wait_valid(1, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL b2b_latency: got %0d, required 8", lat);
    end
    ack();
  endtask

  task automatic test_reset_midflight();
    int   lat;
    logic seen = 1'b0;
    drive_req(8'd90, 8'd9, '{q: 8'd10, r: 8'd0, dz: 1'b0, err: 1'b0});
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || inbus !== 8'd9) begin
      errors++;
      $display("FAIL midrst_wait: got busy=%b inbus=%0d, required 1 9", busy, inbus);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    checks++;
    if ({req_ready, busy, res_valid, res_dz, res_err, beginSignal} !== 6'b100000 ||
        {inbus, res_quotient, res_remainder} !== 24'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got ctrl=%b data=%h, required 100000 000000",
               {req_ready, busy, res_valid, res_dz, res_err, beginSignal},
               {inbus, res_quotient, res_remainder});
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen |= (res_valid === 1'b1);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_silent: got res_valid seen=%b, required 0", seen);
    end
    drive_req(8'd50, 8'd6, '{q: 8'd8, r: 8'd2, dz: 1'b0, err: 1'b0});
    wait_valid(1, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL midrst_fresh_latency: got %0d, required 8", lat);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_timeout();
    test_short_end();
    test_back_to_back();
    test_reset_midflight();
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srt4_host.md
# srt4_host

Host-side sequencer for the SRT4 divider's serial bus. It accepts a dividend/divisor pair over a valid/ready request channel and drives the divider's `inbus`/`beginSignal` launch sequence. It then collects quotient and remainder from `outbus`/`endSignal` and returns them on a valid/ready result channel. It also handles divide-by-zero locally, guards against a hung divider with a timeout, and sits between system logic and the `srt4` instance.

## Interface

Parameters:
- `TIMEOUT`, default 64: maximum number of cycles spent in WAIT_END before the request is aborted with an error.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  high only in IDLE.
- `req_dividend`  in  8  dividend, sampled at request handshake.
- `req_divisor`  in  8  divisor, sampled at request handshake.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `res_quotient`  out  8  quotient.
- `res_remainder`  out  8  remainder.
- `res_dz`  out  1  divisor was zero; no divider launch took place.
- `res_err`  out  1  timeout or `endSignal` protocol violation.
- `inbus`  out  8  driven to the divider's `inbus`.
- `beginSignal`  out  1  driven to the divider's `beginSignal`.
- `outbus`  in  8  from the divider's `outbus`.
- `endSignal`  in  1  from the divider's `endSignal`.
- `busy`  out  1  high in every state except IDLE.

## Operation

**Divider protocol (fixed):**
- Launch cycle: `beginSignal`=1 and `inbus`=dividend.
- Following cycles: `beginSignal`=0 and `inbus`=divisor, held until the result is collected.
- The divider raises `endSignal` for 2 consecutive cycles:
  - first cycle: `outbus`=quotient;
  - second cycle: `outbus`=remainder.

**State machine:** IDLE, LOAD_A, LOAD_B, WAIT_END, CAP_R, DONE.
- **IDLE:**
  - On `req_valid`, latch both operands.
  - If the divisor is 0, go to DONE with `res_dz`=1, quotient 8'hFF, remainder = dividend.
  - Otherwise go to LOAD_A.
- **LOAD_A:** `beginSignal`=1, `inbus`=dividend; then go to LOAD_B.
- **LOAD_B:** `beginSignal`=0, `inbus`=divisor; clear the wait counter; then go to WAIT_END.
- **WAIT_END:**
  - `inbus`=divisor and the counter increments every cycle.
  - On `endSignal`=1, capture the quotient from `outbus` and go to CAP_R.
  - If the counter reaches `TIMEOUT` first, go to DONE with `res_err`=1 and quotient = remainder = 0.
- **CAP_R:**
  - Capture the remainder from `outbus`.
  - If `endSignal`=0 in this cycle, set `res_err`=1; the captured values are still reported.
  - Then go to DONE.
- **DONE:** `res_valid`=1 with all result outputs stable. On `res_ready`, go to IDLE.

**Output and arithmetic rules:**
- `beginSignal` and `inbus` are registered and equal 0 in IDLE and DONE.
- `endSignal` seen outside WAIT_END and CAP_R is ignored.
- The counter is `$clog2(TIMEOUT+1)` bits wide and saturates.
- No arithmetic is performed on operands; they are passed through unchanged.

## Timing

**Reset:**
- `rst` is sampled at a clock edge. On the next cycle the block is in IDLE with:
  - `req_ready`=1, and `busy`=0;
  - `res_valid`, `res_dz`, `res_err`, `beginSignal`=0;
  - `inbus`, `res_quotient`, `res_remainder`=0.
- `rst` in any state aborts the operation in flight. The result is discarded and nothing is reported.

**Latency:**
- Request handshake at cycle T:
  - LOAD_A at T+1, so `beginSignal` is high during T+1 only;
  - LOAD_B at T+2.
- First `endSignal` cycle E gives CAP_R at E+1 and `res_valid` at E+2.
- Divide-by-zero gives `res_valid` at T+1.
- Timeout gives `res_valid` at T+3+`TIMEOUT`.

**Handshakes:**
- A request is taken only when `req_valid` and `req_ready` are both high.
- A result completes when `res_valid` and `res_ready` are both high. `req_ready` returns high in the following cycle.
- One transaction is outstanding at a time; no request is accepted while DONE is stalled.

## Structure

- Package `srt4_host_pkg` holds:
  - the state enum;
  - `DZ_QUOTIENT` = 8'hFF;
  - the bus width constant 8.
- One sub-module, `wait_counter`: a saturating up-counter with clear, enable, and a `hit` output at `TIMEOUT`.
- The divider instance stays outside this block; the two are connected at the top level.

## Test plan

- Request 101/5 against a real `srt4` → one `beginSignal` pulse carrying `inbus`=101, then `inbus`=5; result quotient 20, remainder 1, `res_dz`=0, `res_err`=0.
- Request 37/0 → `beginSignal` never asserted; `res_valid` at T+1 with quotient 8'hFF, remainder 37, `res_dz`=1.
- Stub divider holds `endSignal` at 0 with `TIMEOUT`=8 → `res_err`=1, quotient = remainder = 0, `res_valid` at T+11.
- Stub drives `endSignal` for 1 cycle only (quotient 9, then `outbus`=3) → quotient 9, remainder 3, `res_err`=1.
- Hold `res_ready`=0 for 5 cycles during DONE → result outputs stable and `req_ready`=0 throughout; after the handshake `req_ready`=1 on the next cycle. A back-to-back request 200/7 → quotient 28, remainder 4.
- Assert `rst` during WAIT_END → next cycle all outputs at reset values and no result reported; a fresh request 50/6 → quotient 8, remainder 2.
